mac_seq_ctrl: RTL
=================

// Module: mac_seq_ctrl
// PURPOSE
//  Job sequencer for one MAC lane (4 A-operands x 1 B-operand multiply array, SINGLE/DUAL/QUAD modes).
//  Accepts a job of N operand beats, registers each beat and drives the multiply array.
//  Accumulates the array output into a wide accumulator; returns the sum on a valid/ready result port.
//  Sits between the operand-fetch logic and the combinational multiply block.
// PARAMETERS
//  LEN_WIDTH  8   width of job beat count (max 2^LEN_WIDTH-1 beats)
//  ACC_WIDTH  48  accumulator/result width; must be >= `MAC_INT_WIDTH
// PORTS
//  clk        in   1                   clock, rising edge
//  rst        in   1                   reset, asynchronous, active-low (0 = reset)
//  cfg_valid  in   1                   job request
//  cfg_ready  out  1                   job accepted when cfg_valid&cfg_ready
//  cfg_mode   in   2                   `MAC_SINGLE/`MAC_DUAL/`MAC_QUAD
//  cfg_len    in   LEN_WIDTH           beats in job
//  cfg_init   in   ACC_WIDTH           initial accumulator value
//  op_valid   in   1                   operand beat valid
//  op_ready   out  1                   operand beat accepted when op_valid&op_ready
//  op_a       in   4*`MAC_MIN_WIDTH    {A3,A2,A1,A0}
//  op_b       in   `MAC_MIN_WIDTH      B operand
//  mul_a0..3  out  `MAC_MIN_WIDTH each to multiply array, from stage register
//  mul_b      out  `MAC_MIN_WIDTH      to multiply array
//  mul_cfg    out  2                   latched job mode
//  mul_c      in   `MAC_INT_WIDTH      combinational product from array
//  res_valid  out  1                   result valid; held until res_ready
//  res_ready  in   1                   result consumer ready
//  res_data   out  ACC_WIDTH           accumulated result
//  res_ovf    out  1                   sticky saturation flag (0 without feature)
//  busy       out  1                   state != IDLE
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-job): state=IDLE; acc, count, stage regs, mul_*, res_*, busy = 0.
//  Job in flight is discarded; no partial result is emitted.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: cfg_ready=1, op_ready=0.
//    On cfg handshake, latch mode and len; acc<=cfg_init; res_ovf<=0.
//    cfg_len==0 -> DONE; else RUN.
//  RUN: cfg_ready=0; op_ready=1 while beats_accepted < len.
//    Each op handshake at edge t loads the stage reg (s_valid=1).
//    During cycle t+1, mul_* are driven from the stage reg; at edge t+2, acc <= acc + zext(mul_c).
//    Back-to-back beats sustain 1 beat/cycle. s_valid clears when no handshake occurs.
//    After the last beat's accumulate edge, go to DONE.
//    Latency: last op handshake at edge t -> res_valid=1 from edge t+2.
//  DONE: res_valid=1, res_data=acc, stable until res_ready. Handshake -> IDLE; next cfg accepted >=1 cycle later.
//  op_valid outside RUN is ignored (op_ready=0). cfg_valid outside IDLE is ignored.
//  Mode 2'b11: array returns 0, acc stays cfg_init; job still consumes len beats.
//  mul_* hold their last value while s_valid=0; acc is not updated.
//  Arithmetic: unsigned. mul_c is zero-extended to ACC_WIDTH.
//  Without the saturation feature, overflow wraps modulo 2^ACC_WIDTH.
// CONFIGURATION
//  MAC_SEQ_SAT_EN defined: on carry-out, acc clamps to all-ones; res_ovf set sticky until next job accepted.
//  MAC_SEQ_SAT_EN undefined: wrap-around; res_ovf tied 0.
// STRUCTURE
//  mac_const.vh gains: MAC_SEQ_IDLE/RUN/DONE state encodings (2b) and MAC_SEQ_ACC_WIDTH default.
//  Reuses existing MAC_MIN_WIDTH, MAC_INT_WIDTH, MAC_SINGLE/DUAL/QUAD.
//  Sub-module mac_seq_acc: accumulator register, init load, add, optional saturation, ovf flag.
//  FSM, counter and stage register stay in mac_seq_ctrl.
// TESTING
//  1. SINGLE, len=3, init=0, A0=3 B=4 per beat (array model) -> res_data=36, res_valid at edge t_last+2.
//  2. QUAD, len=1, init=10, op_a=32'h01020304, op_b=8'h02 -> res_data=10+32'h02040608.
//  3. len=0, init=48'h1234 -> DONE next cycle, res_data=48'h1234, no op_ready pulse.
//  4. res_ready held 0 for 5 cycles -> res_data/res_valid stable; cfg_valid ignored until handshake.
//  5. rst low mid-RUN after 2 of 4 beats -> all outputs 0, IDLE; new job (len=1) correct.
//  6. SAT_EN, init=all-ones-5, mul_c=10 -> res_data=all-ones, res_ovf=1; without macro res_data=4, res_ovf=0.

Source files
------------

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared widths, mode/state encodings and operand-beat payload for the MAC lane job sequencer.
package mac_seq_ctrl_pkg;

  localparam int unsigned MAC_MIN_WIDTH     = 8;
  localparam int unsigned MAC_INT_WIDTH     = 32;
  localparam int unsigned MAC_LANES         = 4;
  localparam int unsigned MAC_SEQ_ACC_WIDTH = 48;
  localparam int unsigned MAC_SEQ_LEN_WIDTH = 8;

  typedef enum logic [1:0] {
    MAC_SINGLE = 2'b00,
    MAC_DUAL   = 2'b01,
    MAC_QUAD   = 2'b10,
    MAC_NONE   = 2'b11
  } mac_mode_e;

  typedef enum logic [1:0] {
    MAC_SEQ_IDLE = 2'b00,
    MAC_SEQ_RUN  = 2'b01,
    MAC_SEQ_DONE = 2'b10
  } mac_seq_state_e;

  // One operand beat as held in the stage register: {A3,A2,A1,A0} and B.
  typedef struct packed {
    logic [MAC_LANES-1:0][MAC_MIN_WIDTH-1:0] a;
    logic [MAC_MIN_WIDTH-1:0]                b;
  } mac_op_beat_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job config, operand-beat and result handshake bundle between fetch logic and the sequencer.
interface mac_seq_ctrl_if #(
  parameter int unsigned LEN_WIDTH = mac_seq_ctrl_pkg::MAC_SEQ_LEN_WIDTH,
  parameter int unsigned ACC_WIDTH = mac_seq_ctrl_pkg::MAC_SEQ_ACC_WIDTH
);
  import mac_seq_ctrl_pkg::*;

  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [1:0]                           cfg_mode;
  logic [LEN_WIDTH-1:0]                 cfg_len;
  logic [ACC_WIDTH-1:0]                 cfg_init;

  logic                                 op_valid;
  logic                                 op_ready;
  logic [MAC_LANES*MAC_MIN_WIDTH-1:0]   op_a;
  logic [MAC_MIN_WIDTH-1:0]             op_b;

  logic                                 res_valid;
  logic                                 res_ready;
  logic [ACC_WIDTH-1:0]                 res_data;
  logic                                 res_ovf;

  modport master (
    output cfg_valid, cfg_mode, cfg_len, cfg_init, op_valid, op_a, op_b, res_ready,
    input  cfg_ready, op_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_len, cfg_init, op_valid, op_a, op_b, res_ready,
    output cfg_ready, op_ready, res_valid, res_data, res_ovf
  );

endinterface

// File: rtl/mac_seq_acc.sv
// Wide unsigned accumulator with init load; MAC_SEQ_SAT_EN selects clamp-to-ones + sticky ovf
// instead of modulo wrap-around.
module mac_seq_acc
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = MAC_SEQ_ACC_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load,
  input  logic [ACC_WIDTH-1:0]     i_init,
  input  logic                     i_add_en,
  input  logic [MAC_INT_WIDTH-1:0] i_addend,
  output logic [ACC_WIDTH-1:0]     o_acc,
  output logic                     o_ovf
);

  logic [ACC_WIDTH-1:0] r_acc;

`ifdef MAC_SEQ_SAT_EN
  logic             r_ovf;
  logic [ACC_WIDTH:0] w_sum;

  // Extra MSB captures the carry-out that triggers saturation.
  assign w_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(i_addend);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_init;
      r_ovf <= 1'b0;
    end else if (i_add_en) begin
      if (w_sum[ACC_WIDTH]) begin
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  assign o_ovf = r_ovf;
`else
  logic [ACC_WIDTH-1:0] w_sum;

  assign w_sum = r_acc + ACC_WIDTH'(i_addend);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_init;
    end else if (i_add_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_ovf = 1'b0;
`endif

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for one MAC lane: accepts a job, stages operand beats to the multiply array and
// returns the accumulated sum. Optional saturation via MAC_SEQ_SAT_EN (in mac_seq_acc).
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = MAC_SEQ_LEN_WIDTH,
  parameter int unsigned ACC_WIDTH = MAC_SEQ_ACC_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  mac_seq_ctrl_if.slave            io_bus,
  output logic [MAC_MIN_WIDTH-1:0] o_mul_a0,
  output logic [MAC_MIN_WIDTH-1:0] o_mul_a1,
  output logic [MAC_MIN_WIDTH-1:0] o_mul_a2,
  output logic [MAC_MIN_WIDTH-1:0] o_mul_a3,
  output logic [MAC_MIN_WIDTH-1:0] o_mul_b,
  output logic [1:0]               o_mul_cfg,
  input  logic [MAC_INT_WIDTH-1:0] i_mul_c,
  output logic                     o_busy
);

  mac_seq_state_e       r_state, w_state_next;
  logic [LEN_WIDTH-1:0] r_len, w_len_next;
  logic [LEN_WIDTH-1:0] r_cnt, w_cnt_next;
  logic [1:0]           r_mode;
  mac_op_beat_t         r_stage;
  logic                 r_s_valid;
  logic                 r_cfg_ready, w_cfg_ready_next;
  logic                 r_op_ready, w_op_ready_next;
  logic                 r_res_valid, w_res_valid_next;
  logic                 r_busy, w_busy_next;

  logic                 w_cfg_hs;
  logic                 w_op_hs;
  logic                 w_res_hs;
  logic [ACC_WIDTH-1:0] w_acc;
  logic                 w_ovf;

  assign w_cfg_hs = io_bus.cfg_valid & r_cfg_ready;
  assign w_op_hs  = io_bus.op_valid  & r_op_ready;
  assign w_res_hs = r_res_valid      & io_bus.res_ready;

  // RUN finishes only once every beat is accepted and the stage register has drained into acc.
  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      MAC_SEQ_IDLE: begin
        if (w_cfg_hs) begin
          w_len_next   = io_bus.cfg_len;
          w_cnt_next   = '0;
          w_state_next = (io_bus.cfg_len == '0) ? MAC_SEQ_DONE : MAC_SEQ_RUN;
        end
      end
      MAC_SEQ_RUN: begin
        if (w_op_hs) begin
          w_cnt_next = r_cnt + LEN_WIDTH'(1);
        end
        if ((r_cnt == r_len) && !r_s_valid) begin
          w_state_next = MAC_SEQ_DONE;
        end
      end
      MAC_SEQ_DONE: begin
        if (w_res_hs) begin
          w_state_next = MAC_SEQ_IDLE;
        end
      end
      default: w_state_next = MAC_SEQ_IDLE;
    endcase
    w_cfg_ready_next = (w_state_next == MAC_SEQ_IDLE);
    w_op_ready_next  = (w_state_next == MAC_SEQ_RUN) && (w_cnt_next < w_len_next);
    w_res_valid_next = (w_state_next == MAC_SEQ_DONE);
    w_busy_next      = (w_state_next != MAC_SEQ_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= MAC_SEQ_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_cfg_ready <= 1'b1;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_len       <= w_len_next;
      r_cnt       <= w_cnt_next;
      r_cfg_ready <= w_cfg_ready_next;
      r_op_ready  <= w_op_ready_next;
      r_res_valid <= w_res_valid_next;
      r_busy      <= w_busy_next;
    end
  end

  // Stage register holds its last beat when idle so the array inputs stay quiet.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= 2'b00;
      r_stage   <= '0;
      r_s_valid <= 1'b0;
    end else begin
      r_s_valid <= w_op_hs;
      if (w_cfg_hs) begin
        r_mode <= io_bus.cfg_mode;
      end
      if (w_op_hs) begin
        r_stage.a <= io_bus.op_a;
        r_stage.b <= io_bus.op_b;
      end
    end
  end

  mac_seq_acc #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_acc (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_cfg_hs),
    .i_init   (io_bus.cfg_init),
    .i_add_en (r_s_valid),
    .i_addend (i_mul_c),
    .o_acc    (w_acc),
    .o_ovf    (w_ovf)
  );

  assign o_mul_a0  = r_stage.a[0];
  assign o_mul_a1  = r_stage.a[1];
  assign o_mul_a2  = r_stage.a[2];
  assign o_mul_a3  = r_stage.a[3];
  assign o_mul_b   = r_stage.b;
  assign o_mul_cfg = r_mode;
  assign o_busy    = r_busy;

  assign io_bus.cfg_ready = r_cfg_ready;
  assign io_bus.op_ready  = r_op_ready;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_data  = w_acc;
  assign io_bus.res_ovf   = w_ovf;

endmodule
